// File: rtl/srt_div2_ctrl.sv
// Sequencing controller for a radix-2 SRT divider: latches operands, steps ITER
// digit cycles, assembles the quotient on the fly and applies the final sign fix.
module srt_div2_ctrl #(
  parameter int WIDTH = 8,
  parameter int RW    = WIDTH + 2,
  parameter int ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] NIn,
  input  logic [WIDTH-1:0] DIn,
  input  logic [RW-1:0]    w,
  input  logic [1:0]       q,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] D,
  output logic             state0,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [ITER-1:0]  Quotient,
  output logic [RW-1:0]    Resid,
  output logic             Neg,
  output logic             Err
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, d_q;
  logic [ITER-1:0]  q_q, qm_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    resid_q;
  logic             neg_q, err_q;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = (DIn == '0) ? S_DONE : S_LOAD;
      S_LOAD: state_d = S_ITER;
      S_ITER: if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    Ready  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    state0 = 1'b1;
    case (state_q)
      S_IDLE: Ready = 1'b1;
      S_LOAD: Busy  = 1'b1;
      S_ITER: begin Busy = 1'b1; state0 = 1'b0; end
      S_FIX:  Busy  = 1'b1;
      S_DONE: Done  = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, on-the-fly conversion and result registers.
  // QM tracks Q-1 so a negative final residual selects it with no carry chain.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      n_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      quo_q   <= '0;
      resid_q <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Start) begin
          n_q <= NIn;
          d_q <= DIn;
          if (DIn == '0) begin
            quo_q   <= '0;
            resid_q <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            q_q   <= '0;
            qm_q  <= '1;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q + CW'(1);
          case (q)
            2'b10: begin
              q_q  <= {q_q[ITER-2:0], 1'b1};
              qm_q <= {q_q[ITER-2:0], 1'b0};
            end
            2'b01: begin
              q_q  <= {qm_q[ITER-2:0], 1'b1};
              qm_q <= {qm_q[ITER-2:0], 1'b0};
            end
            default: begin
              // 2'b11 is illegal: counted as a zero digit and flagged
              q_q  <= {q_q[ITER-2:0], 1'b0};
              qm_q <= {qm_q[ITER-2:0], 1'b1};
              if (q == 2'b11) err_q <= 1'b1;
            end
          endcase
        end
        S_FIX: begin
          resid_q <= w;
          neg_q   <= w[RW-1];
          quo_q   <= w[RW-1] ? qm_q : q_q;
        end
        default: ;
      endcase
    end
  end

  assign N        = n_q;
  assign D        = d_q;
  assign Quotient = quo_q;
  assign Resid    = resid_q;
  assign Neg      = neg_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_srt_div2_ctrl.sv
// Bench for srt_div2_ctrl: a phase/arithmetic model of each operation plus a
// per-cycle compare, a datapath stub driving q/w, and literal pins.
module tb_srt_div2_ctrl;
  localparam int W  = 8;
  localparam int RW = W + 2;
  localparam int IT = W;

  logic          Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0;
  logic [W-1:0]  NIn = '0, DIn = '0;
  logic [RW-1:0] w = '0;
  logic [1:0]    q = '0;
  logic [W-1:0]  N, D;
  logic          state0, Ready, Busy, Done, Neg, Err;
  logic [IT-1:0] Quotient;
  logic [RW-1:0] Resid;

  srt_div2_ctrl #(.WIDTH(W), .RW(RW), .ITER(IT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .NIn(NIn), .DIn(DIn),
    .w(w), .q(q), .N(N), .D(D), .state0(state0), .Ready(Ready), .Busy(Busy),
    .Done(Done), .Quotient(Quotient), .Resid(Resid), .Neg(Neg), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Next operation's datapath script, picked up by the model when Start is accepted
  logic [1:0]    nx_dig [IT];
  logic [RW-1:0] nx_w = '0;

  // Model: m_t counts edges since the accepting edge
  logic          m_active = 1'b0, m_div0 = 1'b0;
  int            m_t = 0;
  logic [W-1:0]  m_n = '0, m_d = '0;
  logic [1:0]    m_dig [IT];
  logic [RW-1:0] m_w = '0;
  logic [IT-1:0] r_quo = '0;
  logic [RW-1:0] r_res = '0;
  logic          r_neg = 1'b0, r_err = 1'b0;

  // Signed-digit value of the sequence, minus one when the residual is negative
  function automatic logic [IT-1:0] model_quo(input logic [1:0] dg [IT], input logic neg);
    int v = 0;
    for (int i = 0; i < IT; i++) begin
      if (dg[i] == 2'b10) v += (1 << (IT - 1 - i));
      else if (dg[i] == 2'b01) v -= (1 << (IT - 1 - i));
    end
    if (neg) v -= 1;
    return v[IT-1:0];
  endfunction

  function automatic logic model_err(input logic [1:0] dg [IT]);
    for (int i = 0; i < IT; i++) if (dg[i] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_idle();
    return !m_active || (m_div0 ? (m_t >= 1) : (m_t >= IT + 3));
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_active <= 1'b0; m_t <= 0; m_n <= '0; m_d <= '0;
      r_quo <= '0; r_res <= '0; r_neg <= 1'b0; r_err <= 1'b0;
    end else if (m_idle() && Start) begin
      m_active <= 1'b1; m_t <= 0; m_n <= NIn; m_d <= DIn;
      m_div0 <= (DIn == '0); m_dig <= nx_dig; m_w <= nx_w;
      if (DIn == '0) begin
        r_quo <= '0; r_res <= '0; r_neg <= 1'b0; r_err <= 1'b1;
      end
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (!m_div0 && m_t == IT + 1) begin
        r_quo <= model_quo(m_dig, m_w[RW-1]);
        r_res <= m_w;
        r_neg <= m_w[RW-1];
        r_err <= model_err(m_dig);
      end
    end
  end

  // Datapath stub: scripted digits in ITER cycles, scripted w in FIX, noise elsewhere
  initial forever begin
    @(negedge Clk);
    if (m_active && !m_div0 && m_t >= 1 && m_t <= IT) q = m_dig[m_t-1];
    else q = 2'($urandom);
    if (m_active && !m_div0 && m_t == IT + 1) w = m_w;
    else w = RW'($urandom);
  end

  // Per-cycle compare
  always @(negedge Clk) begin
    logic idle, e_done, e_busy, e_s0;
    idle   = m_idle();
    e_done = m_active && (m_div0 ? (m_t == 0) : (m_t == IT + 2));
    e_busy = m_active && !m_div0 && (m_t <= IT + 1);
    e_s0   = !(m_active && !m_div0 && m_t >= 1 && m_t <= IT);
    chk("Ready", Ready, idle);
    chk("Busy", Busy, e_busy);
    chk("Done", Done, e_done);
    chk("state0", state0, e_s0);
    chk("N", N, m_n);
    chk("D", D, m_d);
    if (idle || e_done) begin
      chk("Quotient", Quotient, r_quo);
      chk("Resid", Resid, r_res);
      chk("Neg", Neg, r_neg);
      chk("Err", Err, r_err);
    end
  end

  // One operation: Start for one cycle, then wait (bounded) for Done.
  // lat = edges after the accepting edge before Done is seen; s0 = state0-low cycles.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [IT-1:0][1:0] digs, input logic [RW-1:0] wv,
                        output int lat, output int s0);
    @(negedge Clk);
    for (int i = 0; i < IT; i++) nx_dig[i] = digs[i];
    nx_w = wv; NIn = n; DIn = d; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat = 0; s0 = 0;
    while (!Done && lat < 30) begin
      if (!state0) s0++;
      NIn = W'($urandom); DIn = W'($urandom);
      @(negedge Clk);
      lat++;
    end
    if (!Done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [IT-1:0][1:0] seq;
  int lat, s0;

  initial begin
    for (int i = 0; i < IT; i++) nx_dig[i] = 2'b00;
    repeat (3) @(negedge Clk);
    chk("rst_Ready", Ready, 1'b1);
    chk("rst_state0", state0, 1'b1);
    chk("rst_Quotient", Quotient, 8'h00);
    chk("rst_Err", Err, 1'b0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // +1,0,-1,+1,0,0,+1,-1 = 128-32+16+2-1 = 0x71
    seq = {2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
    run_op(8'h40, 8'h90, seq, 10'h055, lat, s0);
    chk("A_lat", lat, 10);
    chk("A_state0_low", s0, 8);
    chk("A_quo", Quotient, 8'h71);
    chk("A_neg", Neg, 1'b0);
    chk("A_err", Err, 1'b0);

    run_op(8'h40, 8'h90, seq, 10'h3F0, lat, s0);
    chk("B_quo", Quotient, 8'h70);
    chk("B_neg", Neg, 1'b1);
    chk("B_resid", Resid, 10'h3F0);

    run_op(8'h11, 8'h22, '0, 10'h010, lat, s0);
    chk("Z0_quo", Quotient, 8'h00);
    run_op(8'h11, 8'h22, '0, 10'h200, lat, s0);
    chk("Z1_quo", Quotient, 8'hFF);
    chk("Z1_neg", Neg, 1'b1);

    run_op(8'h33, 8'h00, seq, 10'h155, lat, s0);
    chk("DZ_lat", lat, 0);
    chk("DZ_state0_low", s0, 0);
    chk("DZ_err", Err, 1'b1);
    chk("DZ_quo", Quotient, 8'h00);

    // Illegal digit 3 with Start held through the op and into the next one
    @(negedge Clk);
    seq = {2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < IT; i++) nx_dig[i] = seq[i];
    nx_w = 10'h0A0; NIn = 8'h5A; DIn = 8'h21; Start = 1'b1;
    for (int k = 0; k < 30 && !Done; k++) begin
      @(negedge Clk);
      NIn = W'($urandom); DIn = W'($urandom | 1);
    end
    chk("IL_done", Done, 1'b1);
    chk("IL_err", Err, 1'b1);
    for (int i = 0; i < IT; i++) nx_dig[i] = 2'b10;
    @(negedge Clk);
    for (int k = 0; k < 30 && !Done; k++) begin
      @(negedge Clk);
      NIn = W'($urandom); DIn = W'($urandom | 1);
    end
    Start = 1'b0;
    chk("B2B_done", Done, 1'b1);
    chk("B2B_err", Err, 1'b0);
    chk("B2B_quo", Quotient, 8'hFF);

    // Reset during digit 4
    @(negedge Clk);
    nx_w = 10'h001; NIn = 8'h77; DIn = 8'h12; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("RM_Ready", Ready, 1'b1);
    chk("RM_Busy", Busy, 1'b0);
    chk("RM_state0", state0, 1'b1);
    chk("RM_N", N, 8'h00);
    chk("RM_quo", Quotient, 8'h00);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    run_op(8'h40, 8'h90, {2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10},
           10'h055, lat, s0);
    chk("RM_after_quo", Quotient, 8'h71);

    // Random operations, including divide-by-zero and illegal digits
    for (int r = 0; r < 40; r++) begin
      logic [IT-1:0][1:0] rs;
      logic [W-1:0] rd;
      for (int i = 0; i < IT; i++) rs[i] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rd = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      run_op(W'($urandom), rd, rs, RW'($urandom), lat, s0);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
